// File: rtl/llr_input_loader.sv
// llr_input_loader: collects a frame of channel LLRs from a valid/ready stream,
// saturates each one to the stored width and writes the finished 128-entry row
// into the LLR memory in one cycle, then pulses done_o.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, n_sel_i     begin a frame (IDLE only); code length 0=32 1=64 2/3=128
//   in_valid_i/ready_o   input beat handshake; in_llr_i lane 0 = lowest index
//   mem_wr_o, mem_addr_o one-cycle row write strobe and constant row address
//   mem_data_o           row buffer, entry i at [i*BITWIDTH_LLRS +: BITWIDTH_LLRS]
//   busy_o, done_o       not-IDLE flag, one-cycle completion pulse
module llr_input_loader #(
    parameter int BITWIDTH_IN      = 8,
    parameter int BITWIDTH_LLRS    = 7,
    parameter int LLRS_PER_BEAT    = 8,
    parameter int BITWIDTH_ADDRESS = 2,
    parameter int ROW_ADDR         = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic [1:0]                            n_sel_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [LLRS_PER_BEAT*BITWIDTH_IN-1:0]  in_llr_i,
    output logic                                  mem_wr_o,
    output logic [BITWIDTH_ADDRESS-1:0]           mem_addr_o,
    output logic [128*BITWIDTH_LLRS-1:0]          mem_data_o,
    output logic                                  busy_o,
    output logic                                  done_o
);
    localparam int BEAT_W = LLRS_PER_BEAT * BITWIDTH_LLRS;
    localparam logic [7:0] LAST32  = 8'(32 / LLRS_PER_BEAT - 1);
    localparam logic [7:0] LAST64  = 8'(64 / LLRS_PER_BEAT - 1);
    localparam logic [7:0] LAST128 = 8'(128 / LLRS_PER_BEAT - 1);
    // Symmetric clamp: the most negative stored code is never produced.
    localparam logic signed [BITWIDTH_IN-1:0] MAX_V = BITWIDTH_IN'(2 ** (BITWIDTH_LLRS - 1) - 1);
    localparam logic signed [BITWIDTH_IN-1:0] MIN_V = -MAX_V;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                         state_q;
    logic [7:0]                     cnt_q;
    logic [7:0]                     last_q;
    logic [128*BITWIDTH_LLRS-1:0]   row_q;
    logic [BEAT_W-1:0]              sat_beat;

    function automatic logic [BITWIDTH_LLRS-1:0] sat(input logic signed [BITWIDTH_IN-1:0] x);
        return x > MAX_V ? MAX_V[BITWIDTH_LLRS-1:0] :
               x < MIN_V ? MIN_V[BITWIDTH_LLRS-1:0] : x[BITWIDTH_LLRS-1:0];
    endfunction

    always_comb begin
        sat_beat = '0;
        for (int j = 0; j < LLRS_PER_BEAT; j++)
            sat_beat[j*BITWIDTH_LLRS +: BITWIDTH_LLRS] = sat(in_llr_i[j*BITWIDTH_IN +: BITWIDTH_IN]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                    row_q   <= '0;
                    last_q  <= n_sel_i == 2'd0 ? LAST32 : n_sel_i == 2'd1 ? LAST64 : LAST128;
                end
                LOAD: if (in_valid_i) begin
                    row_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= sat_beat;
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == last_q) state_q <= WRITE;
                end
                WRITE: state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o = state_q == LOAD;
    assign mem_wr_o   = state_q == WRITE;
    assign done_o     = state_q == DONE;
    assign busy_o     = state_q != IDLE;
    assign mem_addr_o = BITWIDTH_ADDRESS'(ROW_ADDR);
    assign mem_data_o = row_q;
endmodule

// File: tb/tb_llr_input_loader.sv
// tb_llr_input_loader: directed self-checking bench for llr_input_loader.
module tb_llr_input_loader;
    logic         clk_i = 0;
    logic         rst_ni = 0;
    logic         start_i = 0;
    logic [1:0]   n_sel_i = 0;
    logic         in_valid_i = 0;
    logic         in_ready_o;
    logic [63:0]  in_llr_i = '0;
    logic         mem_wr_o;
    logic [1:0]   mem_addr_o;
    logic [895:0] mem_data_o;
    logic         busy_o;
    logic         done_o;

    int total = 0;
    int bad = 0;
    int acc = 0;
    int wr_cnt = 0;
    logic [7:0] src [128];
    logic [6:0] exp_row [128];

    llr_input_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .n_sel_i(n_sel_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_llr_i(in_llr_i),
        .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) acc++;
        if (mem_wr_o) wr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_row(input string nm);
        for (int i = 0; i < 128; i++)
            chk($sformatf("%s_e%0d", nm, i), 32'(mem_data_o[i*7 +: 7]), 32'(exp_row[i]));
    endtask

    // Drives one frame from src[], checking handshake timing through WRITE, DONE
    // and the following IDLE; start_i is pulsed during LOAD (at beat glitch_at)
    // and during DONE, neither of which may disturb the frame.
    task automatic run_frame(input logic [1:0] ns, input int nb, input bit bub, input int glitch_at);
        int a0 = acc;
        int w0 = wr_cnt;
        @(negedge clk_i); start_i = 1; n_sel_i = ns;
        @(negedge clk_i); start_i = 0;
        chk("load_ready", 32'(in_ready_o), 1);
        chk("load_busy", 32'(busy_o), 1);
        for (int b = 0; b < nb; b++) begin
            if (bub) repeat ($urandom_range(0, 2)) begin
                in_valid_i = 0;
                in_llr_i = {8{8'h11}};
                @(negedge clk_i);
            end
            for (int j = 0; j < 8; j++) in_llr_i[j*8 +: 8] = src[b*8+j];
            in_valid_i = 1;
            start_i = (b == glitch_at);
            @(negedge clk_i);
        end
        start_i = 0;
        in_valid_i = bub;
        in_llr_i = {8{8'h55}};
        chk("wr_strobe", 32'(mem_wr_o), 1);
        chk("wr_addr", 32'(mem_addr_o), 0);
        chk("wr_ready", 32'(in_ready_o), 0);
        chk("wr_done", 32'(done_o), 0);
        chk("wr_busy", 32'(busy_o), 1);
        @(negedge clk_i);
        chk("dn_done", 32'(done_o), 1);
        chk("dn_wr", 32'(mem_wr_o), 0);
        chk("dn_ready", 32'(in_ready_o), 0);
        chk("dn_busy", 32'(busy_o), 1);
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        in_valid_i = 0;
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_done", 32'(done_o), 0);
        @(negedge clk_i);
        chk("no_extra_frame", 32'(busy_o), 0);
        chk("beats_accepted", 32'(acc - a0), 32'(nb));
        chk("write_pulses", 32'(wr_cnt - w0), 1);
    endtask

    initial begin
        logic [7:0] sat_in [8];
        logic [6:0] sat_out [8];
        sat_in  = '{8'd127, 8'd64, 8'd63, 8'hC1, 8'hC0, 8'h80, 8'h00, 8'hFF};
        sat_out = '{7'h3F, 7'h3F, 7'h3F, 7'h41, 7'h41, 7'h41, 7'h00, 7'h7F};

        #1;
        chk("rst_ready", 32'(in_ready_o), 0);
        chk("rst_wr", 32'(mem_wr_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_addr", 32'(mem_addr_o), 0);
        chk("rst_data", 32'(|mem_data_o), 0);
        @(negedge clk_i); rst_ni = 1;

        // Reset in the middle of a 128-entry frame
        for (int i = 0; i < 128; i++) src[i] = 8'(i % 50 + 1);
        @(negedge clk_i); start_i = 1; n_sel_i = 2;
        @(negedge clk_i); start_i = 0;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 8; j++) in_llr_i[j*8 +: 8] = src[b*8+j];
            in_valid_i = 1;
            @(negedge clk_i);
        end
        in_valid_i = 0;
        #2 rst_ni = 0;
        #1;
        chk("mid_rst_ready", 32'(in_ready_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_wr", 32'(mem_wr_o), 0);
        chk("mid_rst_done", 32'(done_o), 0);
        chk("mid_rst_data", 32'(|mem_data_o), 0);
        chk("mid_rst_no_write", 32'(wr_cnt), 0);
        @(negedge clk_i); rst_ni = 1;

        // N=128, entry i = i mod 64, start pulsed during LOAD
        for (int i = 0; i < 128; i++) begin
            src[i] = 8'(i % 64);
            exp_row[i] = 7'(i % 64);
        end
        run_frame(2'd2, 16, 0, 3);
        check_row("n128");

        // N=128 all +20, then N=32 must zero entries 32..127
        for (int i = 0; i < 128; i++) begin
            src[i] = 8'd20;
            exp_row[i] = 7'd20;
        end
        run_frame(2'd3, 16, 0, -1);
        check_row("n128_20");
        for (int i = 0; i < 128; i++) begin
            src[i] = i < 32 ? 8'(i * 3 - 40) : 8'd99;
            exp_row[i] = i < 32 ? 7'(i * 3 - 40) : 7'd0;
        end
        run_frame(2'd0, 4, 0, 1);
        check_row("n32");

        // Saturation
        for (int i = 0; i < 128; i++) begin
            src[i] = sat_in[i % 8];
            exp_row[i] = i < 32 ? sat_out[i % 8] : 7'd0;
        end
        run_frame(2'd0, 4, 0, -1);
        check_row("sat");

        // N=64 with random bubbles and trailing valid beats
        for (int i = 0; i < 128; i++) begin
            src[i] = 8'(i - 30);
            exp_row[i] = i < 64 ? 7'(i - 30) : 7'd0;
        end
        run_frame(2'd1, 8, 1, 5);
        check_row("n64_bub");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/llr_input_loader.md
Name: llr_input_loader

Overview:
- Upstream of the decoder's 128-entry x 7-bit LLR row memory (depth 3).
- Accepts channel LLRs as a valid/ready stream of LLRS_PER_BEAT signed 8-bit values per beat.
- Saturates each value to 7 bits and assembles one 128-entry row, zero-padding unused entries for short codes.
- Writes the finished row into the memory's channel-LLR row in a single write cycle, then pulses done to start decoding.

Parameters:
- BITWIDTH_IN, 8, width of each incoming signed LLR.
- BITWIDTH_LLRS, 7, width of each stored signed LLR.
- LLRS_PER_BEAT, 8, LLRs per input beat; power of two, must divide 32.
- BITWIDTH_ADDRESS, 2, memory address width.
- ROW_ADDR, 0, memory row that receives channel LLRs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a new frame; sampled only in IDLE.
- n_sel_i  in  2  code length, sampled with start_i: 0=32, 1=64, 2=128, 3=reserved (treated as 128).
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  loader accepts a beat.
- in_llr_i  in  LLRS_PER_BEAT*BITWIDTH_IN  packed LLRs; lane 0 is the lowest LLR index.
- mem_wr_o  out  1  write strobe to the LLR memory.
- mem_addr_o  out  BITWIDTH_ADDRESS  write address.
- mem_data_o  out  128*BITWIDTH_LLRS  row data; entry i sits at bits [i*7 +: 7].
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the row write.

Behaviour:
- Reset (async, rst_ni low): state IDLE; beat counter 0; row buffer all 0; in_ready_o=0, mem_wr_o=0, mem_addr_o=ROW_ADDR, busy_o=0, done_o=0, mem_data_o=0. Reset mid-frame discards the partial row and issues no write.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start_i=1 → latch N from n_sel_i, clear row buffer to 0, clear beat counter, go to LOAD next cycle.
  - Ignore in_valid_i.
- LOAD:
  - in_ready_o=1 combinationally.
  - Beat accepted when in_valid_i && in_ready_o.
  - Accepted beat k writes lanes j=0..P-1 into row entry k*P+j, where P = LLRS_PER_BEAT.
  - Beat counter increments per accepted beat.
  - Beat accepted with counter = N/P-1 → WRITE next cycle; no further beats accepted.
  - in_valid_i low → hold; bubbles are allowed.
- WRITE:
  - Exactly one cycle: mem_wr_o=1, mem_addr_o=ROW_ADDR, in_ready_o=0.
  - Then go to DONE.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
  - busy_o falls in the IDLE cycle that follows.
- Latency: last beat accepted at edge t → mem_wr_o high in cycle t+1, done_o high in cycle t+2. Earliest next start_i is sampled in cycle t+3.
- Saturation, per lane, signed: x>63 → 63; x<-63 → -63 (symmetric; -64 never produced); otherwise x truncated to 7 bits.
- Short codes (N=32/64): entries N..127 remain 0, so padded positions carry zero reliability.
- mem_data_o continuously reflects the row buffer; the memory consumes it only when mem_wr_o=1.
- mem_addr_o is constant ROW_ADDR.
- start_i outside IDLE: ignored, with no effect on the current frame.
- start_i in the same cycle as done_o: ignored, because the FSM is in DONE.
- Each frame's buffer clear on start guarantees no stale data from a longer previous frame.

Test Plan:
- Reset mid-LOAD: after 5 of 16 beats (N=128) pull rst_ni low → all outputs 0, no mem_wr_o pulse; a fresh frame then loads correctly.
- N=128, 16 back-to-back beats, lane value = index mod 64 → one mem_wr_o pulse at address 0; entry i = i mod 64; done_o exactly one cycle later; total 16 beats + 2 cycles.
- N=32 after an N=128 frame of all +20 → entries 0..31 hold the new data, entries 32..127 = 0, 4 beats accepted.
- Saturation: beat containing +127, +64, +63, -63, -64, -128, 0, -1 → stored +63, +63, +63, -63, -63, -63, 0, -1 (7-bit 0x7F).
- Backpressure/bubbles: random in_valid_i gaps with N=64 → exactly 8 beats accepted in order, in_ready_o=0 in WRITE and DONE, extra valid beats not consumed.
- start_i pulsed during LOAD and during DONE → no counter reset, no extra frame; busy_o stays high until the IDLE cycle after done_o.
